// File: rtl/keyboard_transmitter.sv
// PS/2 host-to-keyboard byte transmitter driving open-drain enables for the clock and data lines.
// Define KBD_TX_RETRY_EN to retry a failed frame once before reporting ack_err.
module keyboard_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       in,
  input  logic       kbd_dat,
  output logic       kbd_clk_oe,
  output logic       kbd_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQUEST = 3'd2,
    SHIFT   = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       line_raw;
  logic [1:0]       meta_q, sync_q;
  logic             clk_prev_q;
  logic             clk_sync, dat_sync, fe;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [9:0]       frame_q, frame_d;
  logic             nack_q, nack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             fail;
`ifdef KBD_TX_RETRY_EN
  logic             retry_q, retry_d;
`endif

  // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data line; both idle high.
  assign line_raw = {kbd_dat, in};
  assign clk_sync = sync_q[0];
  assign dat_sync = sync_q[1];
  assign fe       = clk_prev_q & ~clk_sync;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      meta_q     <= line_raw;
      sync_q     <= meta_q;
      clk_prev_q <= sync_q[0];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      nack_q    <= nack_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

`ifdef KBD_TX_RETRY_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    nack_d    = nack_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    fail      = 1'b0;
`ifdef KBD_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      IDLE: begin
        dat_oe_d = 1'b0;
        // A request landing on a completion pulse is dropped.
        if (tx_start && !done_q && !ack_err_q) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d = '0;
          nack_d    = 1'b0;
          state_d   = INHIBIT;
`ifdef KBD_TX_RETRY_EN
          retry_d   = 1'b0;
`endif
        end
      end

      INHIBIT: begin
        dat_oe_d = 1'b0;
        if (inh_cnt_q == INH_LAST) begin
          state_d  = REQUEST;
          to_cnt_d = '0;
          idx_d    = '0;
          dat_oe_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      REQUEST: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (to_cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else if (fe) begin
          dat_oe_d = ~frame_q[idx_q];
          idx_d    = idx_q + 4'd1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (to_cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else if (fe) begin
          dat_oe_d = ~frame_q[idx_q];
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'd9) begin
            state_d = ACK;
          end
        end
      end

      ACK: begin
        to_cnt_d = to_cnt_q + 1'b1;
        dat_oe_d = 1'b0;
        if (to_cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else if (fe) begin
          nack_d  = dat_sync;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        dat_oe_d = 1'b0;
        if (clk_sync && dat_sync) begin
          if (nack_q) begin
            fail = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (fail) begin
      dat_oe_d = 1'b0;
`ifdef KBD_TX_RETRY_EN
      if (!retry_q) begin
        retry_d   = 1'b1;
        inh_cnt_d = '0;
        nack_d    = 1'b0;
        state_d   = INHIBIT;
      end else begin
        ack_err_d = 1'b1;
        state_d   = IDLE;
      end
`else
      ack_err_d = 1'b1;
      state_d   = IDLE;
`endif
    end
  end

  // Line enables and busy follow the next state, so they change one cycle after the deciding edge.
  always_comb begin
    clk_oe_d = (state_d == INHIBIT);
    busy_d   = (state_d != IDLE);
  end

  assign kbd_clk_oe = clk_oe_q;
  assign kbd_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_keyboard_transmitter.sv
// Randomized self-checking bench for keyboard_transmitter with a behavioural PS/2 keyboard model.
`timescale 1ns/1ps
module tb_keyboard_transmitter;

  localparam int INH = 8;
  localparam int TMO = 4000;
`ifdef KBD_TX_RETRY_EN
  localparam int ATTEMPTS = 2;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk;
  logic       resetN;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       kbd_clk_oe, kbd_dat_oe, busy, done, ack_err;
  logic       dev_clk_low, dev_dat_low;
  logic       ps2_clk, ps2_dat;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  assign ps2_clk = ~(kbd_clk_oe | dev_clk_low);
  assign ps2_dat = ~(kbd_dat_oe | dev_dat_low);

  keyboard_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .in         (ps2_clk),
    .kbd_dat    (ps2_dat),
    .kbd_clk_oe (kbd_clk_oe),
    .kbd_dat_oe (kbd_dat_oe),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity_bit(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Pulse monitor: completion pulses must be exclusive and coincide with busy low.
  initial begin
    forever begin
      @(negedge clk);
      if (resetN) begin
        if (done) begin
          done_cnt++;
          check_val("done_busy", busy, 0);
          check_val("done_excl", ack_err, 0);
        end
        if (ack_err) begin
          err_cnt++;
          check_val("err_busy", busy, 0);
        end
      end
    end
  end

  task automatic send_start(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check_val("busy_set", busy, 1);
  endtask

  // Keyboard model: sees the inhibit, clocks out 11 bits (period 200 clk), ACKs on the 11th clock.
  task automatic kbd_device(input bit ack, input int abort_k,
                            output logic [7:0] cap_byte, output logic cap_par,
                            output logic cap_stop, output logic start_bit,
                            output int low_cycles, output bit ok);
    logic [9:0] bits;
    int n;
    bits = '0;
    cap_byte = '0; cap_par = 1'b0; cap_stop = 1'b0; start_bit = 1'b1;
    low_cycles = 0;
    ok = 1'b1;
    n = 0;
    while (!kbd_clk_oe && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!kbd_clk_oe) begin
      ok = 1'b0;
      return;
    end
    while (kbd_clk_oe && low_cycles < 1000) begin
      low_cycles++;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    start_bit = ps2_dat;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      if (k == abort_k) begin
        repeat (10) @(negedge clk);
        return;
      end
      repeat (100) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (50) @(negedge clk);
      bits[k-1] = ps2_dat;
      repeat (50) @(negedge clk);
    end
    cap_byte = bits[7:0];
    cap_par  = bits[8];
    cap_stop = bits[9];
    if (ack) dev_dat_low = 1'b1;
    dev_clk_low = 1'b1;
    repeat (100) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_pulse(input int bound, output bit found, output bit got_done, output bit got_err);
    int n;
    n = 0;
    found = 1'b0; got_done = 1'b0; got_err = 1'b0;
    while (n < bound && !found) begin
      if (done || ack_err) begin
        found    = 1'b1;
        got_done = done;
        got_err  = ack_err;
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic check_frame(input logic [7:0] d, input logic [7:0] cb, input logic cp,
                             input logic cs, input logic sb, input int low, input bit ok);
    check_val("kbd_seen", ok, 1);
    check_val("inhibit_len", low, INH);
    check_val("start_bit", sb, 0);
    check_val("data_byte", cb, d);
    check_val("parity_bit", cp, odd_parity_bit(d));
    check_val("stop_bit", cs, 1);
  endtask

  task automatic run_txn(input logic [7:0] d, input bit ack, input bit poke);
    logic [7:0] cb;
    logic cp, cs, sb;
    int low, n_att;
    bit ok, f, gd, ge;
    n_att = ack ? 1 : ATTEMPTS;
    send_start(d);
    for (int a = 0; a < n_att; a++) begin
      kbd_device(ack, 0, cb, cp, cs, sb, low, ok);
      check_frame(d, cb, cp, cs, sb, low, ok);
    end
    wait_pulse(200, f, gd, ge);
    check_val("pulse_seen", f, 1);
    check_val("done_pulse", gd, ack);
    check_val("ack_err_pulse", ge, !ack);
    if (poke && f) begin
      tx_start = 1'b1;
      tx_data  = ~d;
      @(negedge clk);
      tx_start = 1'b0;
    end
    repeat (20) @(negedge clk);
    check_val("idle_busy", busy, 0);
    check_val("idle_clk_oe", kbd_clk_oe, 0);
    $display("txn data=%02h ack=%0d captured=%02h done=%0d ack_err=%0d", d, ack, cb, gd, ge);
  endtask

  initial begin
    logic [7:0] cb, rd;
    logic cp, cs, sb;
    int low, t0, exp_to, d0, e0, n;
    bit ok, f, gd, ge, rack;

    resetN = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    tx_start = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    check_val("rst_clk_oe", kbd_clk_oe, 0);
    check_val("rst_dat_oe", kbd_dat_oe, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ack_err", ack_err, 0);
    tx_start = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    check_val("post_rst_busy", busy, 0);

    run_txn(8'hED, 1'b1, 1'b1);
    run_txn(8'h01, 1'b1, 1'b0);
    run_txn(8'hFF, 1'b0, 1'b0);

    // Keyboard never clocks: timeout measured from REQUEST entry.
    send_start(8'hF4);
    n = 0;
    while (kbd_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    check_val("to_start_bit", kbd_dat_oe, 1);
`ifdef KBD_TX_RETRY_EN
    exp_to = 2 * TMO + INH;
`else
    exp_to = TMO;
`endif
    wait_pulse(10000, f, gd, ge);
    check_val("to_pulse_seen", f, 1);
    check_val("to_ack_err", ge, 1);
    check_val("to_elapsed", cyc - t0, exp_to);
    check_val("to_clk_oe", kbd_clk_oe, 0);
    check_val("to_dat_oe", kbd_dat_oe, 0);
    repeat (5) @(negedge clk);
    $display("txn data=F4 no-clock elapsed=%0d ack_err=%0d", cyc - t0, ge);

    // Reset while bit 4 of 0xED (a zero) is being driven.
    d0 = done_cnt; e0 = err_cnt;
    send_start(8'hED);
    kbd_device(1'b1, 5, cb, cp, cs, sb, low, ok);
    check_val("abort_dat_oe_pre", kbd_dat_oe, 1);
    resetN = 1'b0;
    tx_start = 1'b1;
    #1;
    check_val("abort_clk_oe", kbd_clk_oe, 0);
    check_val("abort_dat_oe", kbd_dat_oe, 0);
    check_val("abort_busy", busy, 0);
    dev_clk_low = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);
    resetN = 1'b1;
    repeat (20) @(negedge clk);
    check_val("abort_busy_after", busy, 0);
    check_val("abort_no_done", done_cnt, d0);
    check_val("abort_no_err", err_cnt, e0);
    $display("txn data=ED reset at bit 4 done_delta=%0d err_delta=%0d", done_cnt - d0, err_cnt - e0);
    run_txn(8'hED, 1'b1, 1'b0);

    // Second request while busy must be ignored.
    d0 = done_cnt;
    send_start(8'h5A);
    fork
      kbd_device(1'b1, 0, cb, cp, cs, sb, low, ok);
      begin
        repeat (300) @(negedge clk);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    check_frame(8'h5A, cb, cp, cs, sb, low, ok);
    wait_pulse(200, f, gd, ge);
    check_val("dbl_done", gd, 1);
    repeat (300) @(negedge clk);
    check_val("dbl_busy", busy, 0);
    check_val("dbl_one_done", done_cnt - d0, 1);
    $display("txn data=5A (3C ignored) captured=%02h done=%0d", cb, gd);

    for (int i = 0; i < 6; i++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      run_txn(rd, rack, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
